// File: rtl/imem_ctrl_pkg.sv
// Shared constants and FSM encoding for the instruction-memory controller.
package imem_ctrl_pkg;

  localparam int unsigned DEF_ADDR_WIDTH  = 32;
  localparam int unsigned DEF_INSTR_WIDTH = 32;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [3:0] HPROT_IFETCH  = 4'b0010;

  // addi x0, x0, 0
  localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ITCM_RD,
    ST_AHB_DATA,
    ST_AHB_ERR
  } state_t;

endpackage

// File: rtl/imem_ctrl_if.sv
// Fetch, ITCM and AHB-Lite signals of the instruction-memory controller.
// master: controller view; slave: fetch stage / memories view.
interface imem_ctrl_if
  import imem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int unsigned INSTR_WIDTH    = DEF_INSTR_WIDTH,
  parameter int unsigned ITCM_SIZE_LOG2 = 14
);

  logic [ADDR_WIDTH-1:0]       next_pc;
  logic                        instr_read_data_valid;
  logic [INSTR_WIDTH-1:0]      instr_read_data;
  logic                        instr_access_fault;

  logic                        itcm_rd_en;
  logic [ITCM_SIZE_LOG2-3:0]   itcm_addr;
  logic [INSTR_WIDTH-1:0]      itcm_rdata;

  logic [ADDR_WIDTH-1:0]       haddr;
  logic [1:0]                  htrans;
  logic [2:0]                  hsize;
  logic [2:0]                  hburst;
  logic                        hwrite;
  logic [3:0]                  hprot;
  logic                        hready;
  logic                        hresp;
  logic [INSTR_WIDTH-1:0]      hrdata;

  modport master (
    input  next_pc, itcm_rdata, hready, hresp, hrdata,
    output instr_read_data_valid, instr_read_data, instr_access_fault,
           itcm_rd_en, itcm_addr, haddr, htrans, hsize, hburst, hwrite, hprot
  );

  modport slave (
    output next_pc, itcm_rdata, hready, hresp, hrdata,
    input  instr_read_data_valid, instr_read_data, instr_access_fault,
           itcm_rd_en, itcm_addr, haddr, htrans, hsize, hburst, hwrite, hprot
  );

endinterface

// File: rtl/imem_last_fetch_buf.sv
// Single-entry last-fetch buffer: tag compare plus stored data/fault.
// Used only when IMEM_LAST_FETCH_BUF_EN is defined.
module imem_last_fetch_buf
  import imem_ctrl_pkg::*;
#(
  parameter int unsigned TAG_WIDTH  = DEF_ADDR_WIDTH - 2,
  parameter int unsigned DATA_WIDTH = DEF_INSTR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic [TAG_WIDTH-1:0]  req_tag,
  input  logic                  load,
  input  logic [TAG_WIDTH-1:0]  load_tag,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_fault,
  output logic                  hit,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_fault
);

  logic                  entry_valid;
  logic [TAG_WIDTH-1:0]  entry_tag;
  logic [DATA_WIDTH-1:0] entry_data;
  logic                  entry_fault;

  // Hit on the stored entry, or bypass a completion being written this cycle
  always_comb begin
    hit = req && ((entry_valid && (entry_tag == req_tag)) ||
                  (load && (load_tag == req_tag)));
    rsp_data  = entry_data;
    rsp_fault = entry_fault;
  end

  // Entry update on every completion; a hit answers on the following cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      entry_valid <= 1'b0;
      rsp_valid   <= 1'b0;
    end else begin
      rsp_valid <= hit;
      if (load) begin
        entry_valid <= 1'b1;
        entry_tag   <= load_tag;
        entry_data  <= load_data;
        entry_fault <= load_fault;
      end
    end
  end

endmodule

// File: rtl/imem_ctrl.sv
// Instruction-memory controller: routes fetch reads to ITCM or AHB-Lite.
// Optional last-fetch buffer enabled by IMEM_LAST_FETCH_BUF_EN.
module imem_ctrl
  import imem_ctrl_pkg::*;
#(
  parameter int unsigned             ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int unsigned             INSTR_WIDTH    = DEF_INSTR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0]   ITCM_BASE      = '0,
  parameter int unsigned             ITCM_SIZE_LOG2 = 14,
  parameter logic [INSTR_WIDTH-1:0]  NOP_INSTR      = DEF_NOP_INSTR
) (
  input logic         cpu_clk,
  input logic         cpu_rst,
  imem_ctrl_if.master bus
);

  state_t                  state;
  logic                    addr_hold;
  logic [ADDR_WIDTH-1:0]   haddr_q;
  logic [INSTR_WIDTH-1:0]  data_q;

  logic [ADDR_WIDTH-3:0]   pc_word;
  logic                    pc_is_itcm;
  logic                    unused_pc_bits;

  logic                    valid;
  logic                    fault;
  logic                    err_enter;
  logic [INSTR_WIDTH-1:0]  live;
  logic                    launch;
  logic                    hit;
  logic                    itcm_launch;
  logic                    ahb_launch;

  logic                    buf_rsp_valid;
  logic                    buf_rsp_fault;
  logic [INSTR_WIDTH-1:0]  buf_rsp_data;

  // Region decode and word address of the incoming request
  always_comb begin
    pc_word        = bus.next_pc[ADDR_WIDTH-1:2];
    pc_is_itcm     = (bus.next_pc[ADDR_WIDTH-1:ITCM_SIZE_LOG2] ==
                      ITCM_BASE[ADDR_WIDTH-1:ITCM_SIZE_LOG2]);
    unused_pc_bits = ^bus.next_pc[1:0];
  end

  // Completion of the outstanding read and its live data source
  always_comb begin
    valid     = 1'b0;
    fault     = 1'b0;
    err_enter = 1'b0;
    live      = '0;
    case (state)
      ST_ITCM_RD: begin
        valid = 1'b1;
        live  = bus.itcm_rdata;
      end
      ST_AHB_DATA: begin
        if (bus.hready) begin
          valid = 1'b1;
          if (bus.hresp) begin
            fault = 1'b1;
            live  = NOP_INSTR;
          end else begin
            live  = bus.hrdata;
          end
        end else if (bus.hresp) begin
          err_enter = 1'b1;
        end
      end
      ST_AHB_ERR: begin
        if (bus.hready) begin
          valid = 1'b1;
          fault = 1'b1;
          live  = NOP_INSTR;
        end
      end
      default: ;
    endcase
    if (buf_rsp_valid) begin
      valid = 1'b1;
      fault = buf_rsp_fault;
      live  = buf_rsp_data;
    end
    if (cpu_rst) begin
      valid = 1'b0;
      fault = 1'b0;
    end
  end

  // New request whenever nothing is outstanding or the current one completes
  always_comb begin
    launch = !cpu_rst && (((state == ST_IDLE) && !addr_hold) || valid);
  end

  // Steer the launch to a memory port unless the buffer answers it
  always_comb begin
    itcm_launch = launch && !hit && pc_is_itcm;
    ahb_launch  = launch && !hit && !pc_is_itcm;
  end

  // Port drive: hold mux on read data, held address phase while hready is low
  always_comb begin
    bus.instr_read_data_valid = valid;
    bus.instr_access_fault    = fault;
    bus.instr_read_data       = valid ? live : data_q;
    bus.itcm_rd_en            = itcm_launch;
    bus.itcm_addr             = bus.next_pc[ITCM_SIZE_LOG2-1:2];
    bus.htrans                = (ahb_launch || (addr_hold && !cpu_rst)) ?
                                HTRANS_NONSEQ : HTRANS_IDLE;
    bus.haddr                 = cpu_rst ? '0 :
                                (ahb_launch ? {pc_word, 2'b00} : haddr_q);
    bus.hsize                 = HSIZE_WORD;
    bus.hburst                = HBURST_SINGLE;
    bus.hwrite                = 1'b0;
    bus.hprot                 = HPROT_IFETCH;
  end

`ifdef IMEM_LAST_FETCH_BUF_EN
  logic [ADDR_WIDTH-3:0] tag_q;

  // Word address of the request in flight, written into the buffer on completion
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      tag_q <= '0;
    end else if (launch) begin
      tag_q <= pc_word;
    end
  end

  imem_last_fetch_buf #(
    .TAG_WIDTH  (ADDR_WIDTH - 2),
    .DATA_WIDTH (INSTR_WIDTH)
  ) u_last_fetch_buf (
    .clk        (cpu_clk),
    .rst        (cpu_rst),
    .req        (launch),
    .req_tag    (pc_word),
    .load       (valid),
    .load_tag   (tag_q),
    .load_data  (live),
    .load_fault (fault),
    .hit        (hit),
    .rsp_valid  (buf_rsp_valid),
    .rsp_data   (buf_rsp_data),
    .rsp_fault  (buf_rsp_fault)
  );
`else
  // No buffer: every request goes to memory
  always_comb begin
    hit           = 1'b0;
    buf_rsp_valid = 1'b0;
    buf_rsp_fault = 1'b0;
    buf_rsp_data  = '0;
  end
`endif

  // Read FSM, hold register and held AHB address.
  // addr_hold marks a NONSEQ not yet accepted (hready low); state stays IDLE meanwhile.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state     <= ST_IDLE;
      addr_hold <= 1'b0;
      haddr_q   <= '0;
      data_q    <= '0;
    end else begin
      if (valid) begin
        data_q <= live;
      end
      if (ahb_launch) begin
        haddr_q <= {pc_word, 2'b00};
      end
      if (addr_hold) begin
        if (bus.hready) begin
          addr_hold <= 1'b0;
          state     <= ST_AHB_DATA;
        end
      end else if (itcm_launch) begin
        state <= ST_ITCM_RD;
      end else if (ahb_launch) begin
        if (bus.hready) begin
          state <= ST_AHB_DATA;
        end else begin
          state     <= ST_IDLE;
          addr_hold <= 1'b1;
        end
      end else if (valid || launch) begin
        state <= ST_IDLE;
      end else if (err_enter) begin
        state <= ST_AHB_ERR;
      end
    end
  end

endmodule

// File: doc/imem_ctrl.md
Name: imem_ctrl

Overview:
- Instruction-memory controller directly upstream of the fetch stage.
- Takes the fetch stage's combinational next_pc and issues one word read per request. ITCM-region addresses go to a single-cycle ITCM SRAM; all other addresses go to an AHB-Lite master port.
- Returns instr_read_data / instr_read_data_valid to fetch and flags bus errors as instruction access faults.

Parameters:
- ADDR_WIDTH, 32, address width
- INSTR_WIDTH, 32, instruction width
- ITCM_BASE, 32'h0000_0000, ITCM base address; aligned to 2^ITCM_SIZE_LOG2
- ITCM_SIZE_LOG2, 14, ITCM size in bytes = 2^ITCM_SIZE_LOG2
- NOP_INSTR, 32'h0000_0013, instruction returned on fault

Ports:
- cpu_clk  in  1  cpu clock
- cpu_rst  in  1  reset; synchronous, active-high
- next_pc  in  ADDR_WIDTH  fetch address from fetch stage
- instr_read_data_valid  out  1  one-cycle pulse, read data returned
- instr_read_data  out  INSTR_WIDTH  instruction word; held stable between pulses
- instr_access_fault  out  1  asserted with valid when the read got an AHB ERROR
- itcm_rd_en  out  1  ITCM read strobe
- itcm_addr  out  ITCM_SIZE_LOG2-2  ITCM word address
- itcm_rdata  in  INSTR_WIDTH  ITCM data, valid the cycle after itcm_rd_en
- haddr  out  ADDR_WIDTH  AHB address
- htrans  out  2  AHB transfer type: IDLE=0 or NONSEQ=2 only
- hsize  out  3  constant 3'b010 (word)
- hburst  out  3  constant 3'b000 (SINGLE)
- hwrite  out  1  constant 0
- hprot  out  4  constant 4'b0010 (opcode fetch, privileged)
- hready  in  1  AHB ready
- hresp  in  1  AHB response; 1 = ERROR
- hrdata  in  INSTR_WIDTH  AHB read data

Behaviour:
- Region decode: next_pc[ADDR_WIDTH-1:ITCM_SIZE_LOG2] == ITCM_BASE upper bits selects ITCM; anything else selects AHB.
- Address alignment: next_pc[1:0] is ignored and both ports see a word-aligned address. Misalignment is reported by fetch, not here.
- FSM states:
  - IDLE: entered from reset.
  - ITCM_RD: one ITCM read outstanding.
  - AHB_DATA: AHB data phase outstanding.
  - AHB_ERR: second cycle of the AHB error response.
- Issue rule: a new read of next_pc launches in any cycle where the state is IDLE, or the outstanding read completes (instr_read_data_valid=1 that cycle). Reads are therefore back-to-back.
- ITCM launch: itcm_rd_en=1 and itcm_addr=next_pc[ITCM_SIZE_LOG2-1:2], then go to ITCM_RD. Next cycle: valid=1 and instr_read_data=itcm_rdata. Latency is 1 cycle, throughput 1 per cycle.
- AHB launch: htrans=NONSEQ and haddr={next_pc[ADDR_WIDTH-1:2],2'b00}, then go to AHB_DATA.
  - The address phase is held until hready=1. In AHB_DATA, each hready=0 cycle is a wait state.
  - hready=1 with hresp=0: valid=1 and data=hrdata. Minimum latency is 1 cycle after address acceptance.
- AHB error:
  - hresp=1 with hready=0 in AHB_DATA: drive htrans=IDLE and go to AHB_ERR.
  - In AHB_ERR, hready=1 gives valid=1, instr_access_fault=1 and instr_read_data=NOP_INSTR.
  - If the second ERROR cycle is missing (hready=1, hresp=0), it is treated as the same fault completion.
- Hold register: instr_read_data is driven from a mux of the live source and a hold register loaded on every valid. Outside valid cycles it equals the last returned word.
- Region change: the next request may target either region. No dead cycle between an ITCM completion and an AHB launch, or the reverse.
- Reset values: valid=0, fault=0, instr_read_data=0, itcm_rd_en=0, htrans=IDLE, haddr=0, state=IDLE.
- Reset mid-operation: cpu_rst aborts on the next edge. htrans returns to IDLE and the in-flight AHB response is ignored, with no valid pulse.
- Post-reset: the first read is issued in the first cycle cpu_rst is low.

Optional Feature:
- Macro: IMEM_LAST_FETCH_BUF_EN.
- With the macro: a single-entry buffer holds tag (word address), data, fault and a valid bit.
  - It is loaded on every completion and invalidated on reset.
  - A request whose word address matches a valid tag issues no ITCM or AHB access and returns valid next cycle from the buffer.
  - This removes repeated bus traffic while the fetch stage stalls re-requesting the same pc.
- Without the macro: every request accesses memory.

Decomposition:
- Shared package/defines:
  - ADDR_WIDTH and INSTR_WIDTH defines.
  - HTRANS_IDLE, HTRANS_NONSEQ, HSIZE_WORD, HBURST_SINGLE and HPROT_IFETCH constants.
  - NOP encoding.
  - FSM state encodings.
- Sub-module: imem_last_fetch_buf, which holds the tag compare and storage. It is instantiated only under the macro.

Test Plan:
- ITCM streaming: next_pc 0x0,0x4,0x8 on consecutive cycles, itcm_rdata A,B,C → valid on 3 consecutive cycles with data A,B,C; itcm_addr 0,1,2.
- AHB with wait states: next_pc 0x2000_0000, hready low for 2 data cycles, hrdata 0x1234_5678 → valid exactly once, 3 cycles after address acceptance; htrans=NONSEQ for one cycle only.
- AHB error: hresp=1/hready=0 then hresp=1/hready=1 → htrans IDLE in the first error cycle; valid=1, fault=1, data=0x0000_0013.
- Region switch: ITCM read at 0x100 completes while next_pc=0x2000_0040 → htrans=NONSEQ with haddr=0x2000_0040 in that same completion cycle.
- Reset mid-transfer: cpu_rst asserted during an AHB wait state, then hready=1 → no valid pulse; htrans IDLE; first read issued the cycle after release.
- IMEM_LAST_FETCH_BUF_EN: same next_pc 0x2000_0010 requested 3 times → a single AHB NONSEQ; three valid pulses with identical data.
